// File: rtl/core_ep_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_ep_arb_if
//  Description : Requester-side bundle for the PCIe endpoint transmit arbiter.
//                Carries the per-requester request/drive levels toward the
//                arbiter and the grant, TX-mux select and error flags back.
//  Ports       : req_ep    - per-requester request level
//                drv_ep    - per-requester "driving endpoint" level
//                my_trn    - one-hot registered grant
//                gnt_vld   - a grant is outstanding
//                gnt_idx   - index of current or last grantee
//                drv_act   - TX mux enable
//                to_err    - watchdog revoke pulse
//                proto_err - drive-without-grant pulse
//  Modports    : master - requester / TX-mux side
//                slave  - arbiter side
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_ep_arb_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) ();
    logic [N_REQ-1:0] req_ep;
    logic [N_REQ-1:0] drv_ep;
    logic [N_REQ-1:0] my_trn;
    logic             gnt_vld;
    logic [IDX_W-1:0] gnt_idx;
    logic             drv_act;
    logic             to_err;
    logic             proto_err;

    modport master (
        output req_ep,
        output drv_ep,
        input  my_trn,
        input  gnt_vld,
        input  gnt_idx,
        input  drv_act,
        input  to_err,
        input  proto_err
    );

    modport slave (
        input  req_ep,
        input  drv_ep,
        output my_trn,
        output gnt_vld,
        output gnt_idx,
        output drv_act,
        output to_err,
        output proto_err
    );
endinterface
`default_nettype wire

// File: rtl/core_ep_arb.sv
`default_nettype none
// ============================================================================
//  Module      : core_ep_arb
//  Description : Round-robin owner of the PCIe endpoint transmit interface.
//                Grants one of N_REQ requesters at a time with a registered
//                one-hot my_trn, tracks the grantee's drv_ep ownership window
//                until release, revokes grants that are never taken up within
//                GRANT_TO cycles, and flags drv_ep from non-grantees.
//  Ports       : clk  - core clock
//                rst  - asynchronous active-high reset
//                ep   - core_ep_arb_if.slave (req_ep, drv_ep in;
//                       my_trn, gnt_vld, gnt_idx, drv_act, to_err,
//                       proto_err out)
//  Parameters  : N_REQ    - number of requesters (2..8)
//                IDX_W    - width of gnt_idx, 2**IDX_W >= N_REQ
//                GRANT_TO - cycles allowed from grant to drv_ep (1..65535)
//  Revision    : 1.0 - initial release
// ============================================================================
module core_ep_arb #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int GRANT_TO = 1024
) (
    input  wire logic   clk,
    input  wire logic   rst,
    core_ep_arb_if.slave ep
);

    localparam int               c_WD_W    = 16;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(GRANT_TO - 1);
    localparam logic [N_REQ-1:0]  c_ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [N_REQ-1:0]   r_my_trn;
    logic [c_WD_W-1:0]  r_wdog;
    logic               r_to_err;
    logic               r_proto_err;

    logic               w_any;
    logic [IDX_W-1:0]   w_sel;
    logic               w_own_drv;
    logic               w_grant;
    logic               w_release;
    logic               w_revoke;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_intruder;

    // Modulo-N_REQ wrap of a requester offset.
    function automatic logic [IDX_W-1:0] f_wrap(input int v);
        return IDX_W'(v % N_REQ);
    endfunction

    // Rotating priority search: first set request at ptr, ptr+1, ... .
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any && ep.req_ep[f_wrap(int'(r_ptr) + i)]) begin
                w_any = 1'b1;
                w_sel = f_wrap(int'(r_ptr) + i);
            end
        end
    end

    assign w_own_drv  = ep.drv_ep[r_gnt_idx];
    assign w_next_idx = (r_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    // my_trn is zero in IDLE and one-hot on the grantee otherwise, so any
    // drv_ep bit outside it is a drive without ownership.
    assign w_intruder = |(ep.drv_ep & ~r_my_trn);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and transition strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        w_revoke    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                // drv_ep takes priority over an expiring watchdog.
                if (w_own_drv) begin
                    w_state_nxt = S_BUSY;
                end else if (r_wdog == c_WD_LAST) begin
                    w_revoke    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!w_own_drv) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, pointer, watchdog and error registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_my_trn    <= '0;
            r_wdog      <= '0;
            r_to_err    <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_to_err    <= w_revoke;
            r_proto_err <= w_intruder;

            if (w_grant) begin
                r_my_trn  <= c_ONE << w_sel;
                r_gnt_idx <= w_sel;
                r_wdog    <= '0;
            end else if (r_state == S_GRANT) begin
                r_wdog <= r_wdog + 1'b1;
            end

            // Pointer moves past the grantee only when its window ends,
            // so a fast re-requester queues behind everyone else pending.
            if (w_release || w_revoke) begin
                r_my_trn <= '0;
                r_ptr    <= w_next_idx;
            end
        end
    end

    assign ep.my_trn    = r_my_trn;
    assign ep.gnt_vld   = (r_state != S_IDLE);
    assign ep.gnt_idx   = r_gnt_idx;
    assign ep.drv_act   = w_own_drv && (r_state == S_BUSY);
    assign ep.to_err    = r_to_err;
    assign ep.proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_core_ep_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_ep_arb
//  Description : Directed self-checking bench for core_ep_arb with a
//                shortened watchdog (GRANT_TO = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_ep_arb;

    localparam int c_N   = 4;
    localparam int c_IW  = 2;
    localparam int c_TO  = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    core_ep_arb_if #(.N_REQ(c_N), .IDX_W(c_IW)) ep ();

    core_ep_arb #(
        .N_REQ   (c_N),
        .IDX_W   (c_IW),
        .GRANT_TO(c_TO)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .ep (ep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int order [4] = '{0, 1, 3, 0};

        rst       = 1'b1;
        ep.req_ep = '0;
        ep.drv_ep = '0;
        #1;
        check("rst_my_trn",    32'(ep.my_trn),    0);
        check("rst_gnt_vld",   32'(ep.gnt_vld),   0);
        check("rst_gnt_idx",   32'(ep.gnt_idx),   0);
        check("rst_drv_act",   32'(ep.drv_act),   0);
        check("rst_to_err",    32'(ep.to_err),    0);
        check("rst_proto_err", 32'(ep.proto_err), 0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_no_req", 32'(ep.my_trn), 0);

        // ---- single requester ----
        ep.req_ep = 4'b0010;
        step();
        check("single_grant",   32'(ep.my_trn),  32'h2);
        check("single_gnt_vld", 32'(ep.gnt_vld), 1);
        check("single_gnt_idx", 32'(ep.gnt_idx), 1);
        ep.req_ep = 4'b0000;
        ep.drv_ep = 4'b0010;
        #1;
        check("single_drv_act_in_grant", 32'(ep.drv_act), 0);
        step();
        check("single_drv_act_busy", 32'(ep.drv_act), 1);
        check("single_hold",         32'(ep.my_trn),  32'h2);
        step();
        step();
        step();
        check("single_busy_long", 32'(ep.drv_act), 1);
        ep.drv_ep = 4'b0000;
        #1;
        check("single_drv_act_drop", 32'(ep.drv_act), 0);
        check("single_trn_till_edge", 32'(ep.my_trn), 32'h2);
        step();
        check("single_release_trn",  32'(ep.my_trn),  0);
        check("single_release_vld",  32'(ep.gnt_vld), 0);
        check("single_idx_hold",     32'(ep.gnt_idx), 1);

        // ---- contention, req 1011 held ----
        pulse_reset();
        ep.req_ep = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("cont_trn_%0d", k), 32'(ep.my_trn),  32'(1 << order[k]));
            check($sformatf("cont_idx_%0d", k), 32'(ep.gnt_idx), 32'(order[k]));
            ep.drv_ep = 4'(1 << order[k]);
            step();
            step();
            step();
            ep.drv_ep = 4'b0000;
            step();
            check($sformatf("cont_gap_trn_%0d", k), 32'(ep.my_trn),  0);
            check($sformatf("cont_gap_vld_%0d", k), 32'(ep.gnt_vld), 0);
        end
        ep.req_ep = 4'b0000;

        // ---- back-off: 0 pulses drv_ep, 2 pending ----
        pulse_reset();
        ep.req_ep = 4'b0101;
        step();
        check("bo_grant0", 32'(ep.my_trn), 32'h1);
        ep.req_ep = 4'b0100;
        ep.drv_ep = 4'b0001;
        step();
        ep.drv_ep = 4'b0000;
        step();
        check("bo_release", 32'(ep.my_trn), 0);
        ep.req_ep = 4'b0101;
        step();
        check("bo_grant2_trn", 32'(ep.my_trn),  32'h4);
        check("bo_grant2_idx", 32'(ep.gnt_idx), 2);
        ep.req_ep = 4'b0001;
        ep.drv_ep = 4'b0100;
        step();
        ep.drv_ep = 4'b0000;
        step();
        step();
        check("bo_grant0_again", 32'(ep.my_trn), 32'h1);
        ep.req_ep = 4'b0000;
        ep.drv_ep = 4'b0001;
        step();
        ep.drv_ep = 4'b0000;
        step();

        // ---- watchdog revoke on requester 2 ----
        ep.req_ep = 4'b0100;
        step();
        check("wd_grant", 32'(ep.my_trn), 32'h4);
        ep.req_ep = 4'b0000;
        repeat (7) step();
        check("wd_before_trn",   32'(ep.my_trn), 32'h4);
        check("wd_before_toerr", 32'(ep.to_err), 0);
        step();
        check("wd_revoke_trn",   32'(ep.my_trn),  0);
        check("wd_revoke_vld",   32'(ep.gnt_vld), 0);
        check("wd_revoke_toerr", 32'(ep.to_err),  1);
        step();
        check("wd_toerr_pulse", 32'(ep.to_err), 0);
        ep.req_ep = 4'b1011;
        step();
        check("wd_ptr_is_3", 32'(ep.gnt_idx), 3);
        ep.req_ep = 4'b0000;
        ep.drv_ep = 4'b1000;
        step();
        ep.drv_ep = 4'b0000;
        step();

        // ---- drv_ep rising on the final watchdog cycle wins ----
        ep.req_ep = 4'b0001;
        step();
        ep.req_ep = 4'b0000;
        repeat (7) step();
        ep.drv_ep = 4'b0001;
        step();
        check("tie_no_toerr", 32'(ep.to_err),  0);
        check("tie_vld",      32'(ep.gnt_vld), 1);
        check("tie_drv_act",  32'(ep.drv_act), 1);
        ep.drv_ep = 4'b0000;
        step();

        // ---- protocol error while 1 is granted ----
        ep.req_ep = 4'b0010;
        step();
        check("pe_grant1", 32'(ep.my_trn), 32'h2);
        ep.req_ep = 4'b0000;
        ep.drv_ep = 4'b1000;
        step();
        check("pe_pulse",      32'(ep.proto_err), 1);
        check("pe_grant_kept", 32'(ep.my_trn),    32'h2);
        ep.drv_ep = 4'b0000;
        step();
        check("pe_pulse_end", 32'(ep.proto_err), 0);
        ep.drv_ep = 4'b0010;
        step();
        check("pe_owner_busy",  32'(ep.drv_act),   1);
        check("pe_owner_legal", 32'(ep.proto_err), 0);
        ep.drv_ep = 4'b0000;
        step();
        ep.drv_ep = 4'b0001;
        step();
        check("pe_idle_drive", 32'(ep.proto_err), 1);
        ep.drv_ep = 4'b0000;
        step();

        // ---- asynchronous reset mid-BUSY ----
        ep.req_ep = 4'b0001;
        step();
        check("rb_grant0", 32'(ep.gnt_idx), 0);
        ep.req_ep = 4'b0000;
        ep.drv_ep = 4'b0001;
        step();
        check("rb_busy", 32'(ep.drv_act), 1);
        #3;
        rst = 1'b1;
        #1;
        check("rb_my_trn",    32'(ep.my_trn),    0);
        check("rb_gnt_vld",   32'(ep.gnt_vld),   0);
        check("rb_gnt_idx",   32'(ep.gnt_idx),   0);
        check("rb_drv_act",   32'(ep.drv_act),   0);
        check("rb_to_err",    32'(ep.to_err),    0);
        check("rb_proto_err", 32'(ep.proto_err), 0);
        step();
        rst       = 1'b0;
        ep.drv_ep = 4'b0000;
        ep.req_ep = 4'b0101;
        step();
        check("rb_ptr0_trn", 32'(ep.my_trn),  32'h1);
        check("rb_ptr0_idx", 32'(ep.gnt_idx), 0);
        ep.req_ep = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
